fpu_arbiter: RTL and testbench

Shares the single FPU between `NUM_REQ` requesters. Each requester presents a complete operation (two operands and an opcode) with a valid/ready handshake. The block grants requesters round-robin, drives the FPU operand and operation inputs, and holds them stable for the FPU's fixed latency. It then captures `Result` and returns it to the owning requester through a response handshake. It sits between the requesting units and the FPU and is the only driver of the FPU's inputs.

---
 rtl/fpu_arb_pkg.sv | 17 +
 rtl/fpu_rr_arbiter.sv | 29 ++
 rtl/fpu_arbiter.sv | 127 ++++++++++++
 tb/tb_fpu_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_arb_pkg.sv
// Shared types and constants for the FPU arbiter: opcodes, quiet NaN, FSM states.
package fpu_arb_pkg;

    localparam logic [2:0]  OP_ADD = 3'b000;
    localparam logic [2:0]  OP_SUB = 3'b001;
    localparam logic [2:0]  OP_MUL = 3'b010;
    localparam logic [2:0]  OP_DIV = 3'b011;
    localparam logic [31:0] QNAN   = 32'h7FC00000;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_e;

    // Only 000..011 are defined; the whole 1xx half of the code space is illegal.
    function automatic logic op_illegal(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/fpu_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module fpu_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDXW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDXW-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDXW-1:0]    idx,
    output logic               any
);

    always_comb begin
        int cand;
        cand = 0;
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IDXW'(cand);
            end
        end
    end

endmodule

// File: rtl/fpu_arbiter.sv
// Round-robin sharing of one fixed-latency FPU among NUM_REQ requesters.
// Optional FPU_ARB_OPCHECK_EN: reject 1xx opcodes locally with a QNaN error response.
module fpu_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int FPU_LATENCY = 1
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [NUM_REQ-1:0]    ReqValid,
    input  logic [32*NUM_REQ-1:0] ReqOperand1,
    input  logic [32*NUM_REQ-1:0] ReqOperand2,
    input  logic [3*NUM_REQ-1:0]  ReqOperation,
    output logic [NUM_REQ-1:0]    ReqReady,
    output logic [NUM_REQ-1:0]    RespValid,
    input  logic [NUM_REQ-1:0]    RespReady,
    output logic [31:0]           RespResult,
    output logic                  RespError,
    output logic [31:0]           FpuOperand1,
    output logic [31:0]           FpuOperand2,
    output logic [2:0]            FpuOperation,
    input  logic [31:0]           FpuResult
);

    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW   = $clog2(FPU_LATENCY + 1);

    arb_state_e           state_q, state_d;
    logic [IDXW-1:0]      ptr_q, owner_q, gnt_idx;
    logic [NUM_REQ-1:0]   gnt;
    logic                 any;
    logic [CW-1:0]        cnt_q;
    logic [31:0]          sel_op1, sel_op2;
    logic [2:0]           sel_op;
    logic                 accept, illegal, capture, done;

    fpu_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDXW(IDXW)) u_rr (
        .req (ReqValid),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (any)
    );

    assign sel_op1 = ReqOperand1[int'(gnt_idx)*32 +: 32];
    assign sel_op2 = ReqOperand2[int'(gnt_idx)*32 +: 32];
    assign sel_op  = ReqOperation[int'(gnt_idx)*3 +: 3];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        ReqReady = '0;
        accept   = 1'b0;
        illegal  = 1'b0;
        capture  = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: if (any) begin
                ReqReady = gnt;
                accept   = 1'b1;
`ifdef FPU_ARB_OPCHECK_EN
                illegal  = op_illegal(sel_op);
`endif
                state_d  = illegal ? RESP : BUSY;
            end
            BUSY: if (cnt_q == CW'(1)) begin
                capture = 1'b1;
                state_d = RESP;
            end
            RESP: if (RespReady[owner_q]) begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        RespValid = '0;
        if (state_q == RESP) RespValid[owner_q] = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ptr_q        <= '0;
            owner_q      <= '0;
            cnt_q        <= '0;
            RespResult   <= '0;
            FpuOperand1  <= '0;
            FpuOperand2  <= '0;
            FpuOperation <= '0;
        end else begin
            if (accept) begin
                owner_q <= gnt_idx;
                // Rejected opcodes leave the FPU inputs exactly as they were.
                if (!illegal) begin
                    FpuOperand1  <= sel_op1;
                    FpuOperand2  <= sel_op2;
                    FpuOperation <= sel_op;
                    cnt_q        <= CW'(FPU_LATENCY);
                end
            end
            if (state_q == BUSY) cnt_q <= cnt_q - CW'(1);
            if (capture) RespResult <= FpuResult;
            if (accept && illegal) RespResult <= QNAN;
            if (done) ptr_q <= (owner_q == IDXW'(NUM_REQ - 1)) ? '0 : owner_q + IDXW'(1);
        end
    end

`ifdef FPU_ARB_OPCHECK_EN
    logic err_q;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)                err_q <= 1'b0;
        else if (accept && illegal) err_q <= 1'b1;
        else if (capture)           err_q <= 1'b0;
    end
    assign RespError = err_q;
`else
    assign RespError = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_arbiter.sv
// Self-checking bench for fpu_arbiter with a behavioural single-precision FPU stub.
module tb_fpu_arbiter;
    import fpu_arb_pkg::*;

    localparam int NR  = 4;
    localparam int LAT = 1;
`ifdef FPU_ARB_OPCHECK_EN
    localparam bit OPCHK = 1'b1;
`else
    localparam bit OPCHK = 1'b0;
`endif

    logic            CLK = 1'b0;
    logic            RST_N = 1'b0;
    logic [NR-1:0]   ReqValid;
    logic [32*NR-1:0] ReqOperand1, ReqOperand2;
    logic [3*NR-1:0] ReqOperation;
    logic [NR-1:0]   ReqReady, RespValid, RespReady;
    logic [31:0]     RespResult;
    logic            RespError;
    logic [31:0]     FpuOperand1, FpuOperand2, FpuResult;
    logic [2:0]      FpuOperation;

    int errors = 0;
    int checks = 0;
    int mptr   = 0;

    always #5 CLK = ~CLK;

    fpu_arbiter #(.NUM_REQ(NR), .FPU_LATENCY(LAT)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .ReqValid(ReqValid), .ReqOperand1(ReqOperand1), .ReqOperand2(ReqOperand2),
        .ReqOperation(ReqOperation), .ReqReady(ReqReady),
        .RespValid(RespValid), .RespReady(RespReady),
        .RespResult(RespResult), .RespError(RespError),
        .FpuOperand1(FpuOperand1), .FpuOperand2(FpuOperand2),
        .FpuOperation(FpuOperation), .FpuResult(FpuResult)
    );

    function automatic real s2r(input logic [31:0] s);
        logic [63:0] d;
        if (s[30:23] == 8'h00)      d = {s[31], 63'b0};
        else if (s[30:23] == 8'hFF) d = {s[31], 11'h7FF, s[22:0], 29'b0};
        else                        d = {s[31], 11'(s[30:23]) + 11'd896, s[22:0], 29'b0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2s(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        e = d[62:52];
        if (e <= 11'd896)  return {d[63], 31'b0};
        if (e >= 11'd1151) return {d[63], 8'hFF, 23'h0};
        return {d[63], 8'(e - 11'd896), d[51:29]};
    endfunction

    function automatic logic [31:0] fpu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op);
        case (op)
            OP_ADD: return r2s(s2r(a) + s2r(b));
            OP_SUB: return r2s(s2r(a) - s2r(b));
            OP_MUL: return r2s(s2r(a) * s2r(b));
            OP_DIV: return (s2r(b) == 0.0) ? 32'h7F800000 : r2s(s2r(a) / s2r(b));
            default: return a ^ b;
        endcase
    endfunction

    always_comb FpuResult = fpu_fn(FpuOperand1, FpuOperand2, FpuOperation);

    function automatic logic [31:0] rand_fp();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(110, 140)), 23'($urandom)};
    endfunction

    // Round-robin rule: first requester at or after ptr, wrapping.
    function automatic int pick(input logic [NR-1:0] m, input int p);
        for (int k = 0; k < NR; k++) begin
            if (m[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        ReqValid = '0;
        RespReady = '0;
        tick();
        RST_N = 1'b1;
        mptr = 0;
    endtask

    task automatic run_txn(input logic [NR-1:0] mask, input bit fix, input int fr,
                           input logic [31:0] fa, input logic [31:0] fb, input logic [2:0] fo,
                           input int hold, output logic [31:0] got);
        logic [31:0] e1, e2, p1, p2, er;
        logic [2:0]  eo, po;
        int g, n;
        bit ill;
        for (int i = 0; i < NR; i++) begin
            ReqOperand1[i*32 +: 32] = rand_fp();
            ReqOperand2[i*32 +: 32] = rand_fp();
            ReqOperation[i*3 +: 3]  = 3'($urandom_range(0, 3));
        end
        if (fix) begin
            ReqOperand1[fr*32 +: 32] = fa;
            ReqOperand2[fr*32 +: 32] = fb;
            ReqOperation[fr*3 +: 3]  = fo;
        end
        RespReady = '0;
        ReqValid  = mask;
        #1;
        g = pick(mask, mptr);
        chk("grant", 32'(ReqReady), 32'(1) << g);
        e1 = ReqOperand1[g*32 +: 32];
        e2 = ReqOperand2[g*32 +: 32];
        eo = ReqOperation[g*3 +: 3];
        p1 = FpuOperand1;
        p2 = FpuOperand2;
        po = FpuOperation;
        ill = OPCHK && eo[2];
        er  = ill ? QNAN : fpu_fn(e1, e2, eo);
        tick();
        ReqValid = '1;
        #1;
        chk("fpu_op1", FpuOperand1, ill ? p1 : e1);
        chk("fpu_op2", FpuOperand2, ill ? p2 : e2);
        chk("fpu_opc", 32'(FpuOperation), 32'(ill ? po : eo));
        chk("ready_busy", 32'(ReqReady), 32'h0);
        n = 0;
        while (!(|RespValid) && n < 8) begin
            tick();
            n++;
        end
        chk("latency", n, ill ? 0 : LAT);
        chk("resp_valid", 32'(RespValid), 32'(1) << g);
        chk("resp_result", RespResult, er);
        chk("resp_error", 32'(RespError), 32'(ill));
        got = RespResult;
        repeat (hold) begin
            RespReady = 4'($urandom) & ~(4'(1) << g);
            tick();
            chk("hold_valid", 32'(RespValid), 32'(1) << g);
            chk("hold_result", RespResult, er);
            chk("hold_ready", 32'(ReqReady), 32'h0);
        end
        ReqValid  = '0;
        RespReady = 4'(1) << g;
        tick();
        RespReady = '0;
        chk("resp_done", 32'(RespValid), 32'h0);
        mptr = (g + 1) % NR;
    endtask

    initial begin
        logic [31:0] res;
        ReqValid = '0;
        ReqOperand1 = '0;
        ReqOperand2 = '0;
        ReqOperation = '0;
        RespReady = '0;
        #2;
        chk("rst_req_ready", 32'(ReqReady), 32'h0);
        chk("rst_resp_valid", 32'(RespValid), 32'h0);
        chk("rst_result", RespResult, 32'h0);
        chk("rst_error", 32'(RespError), 32'h0);
        chk("rst_fpu_op1", FpuOperand1, 32'h0);
        chk("rst_fpu_op2", FpuOperand2, 32'h0);
        chk("rst_fpu_opc", 32'(FpuOperation), 32'h0);
        tick();
        RST_N = 1'b1;

        // single add, then back-pressure, then an illegal opcode
        run_txn(4'b0001, 1'b1, 0, 32'h3F800000, 32'h40000000, OP_ADD, 0, res);
        chk("add_result", res, 32'h40400000);
        run_txn(4'b1111, 1'b0, 0, 32'h0, 32'h0, OP_ADD, 5, res);
        run_txn(4'b0100, 1'b1, 2, rand_fp(), rand_fp(), 3'b101, 1, res);

        // contention from reset with responses always accepted
        RST_N = 1'b0;
        ReqValid = '1;
        RespReady = '1;
        tick();
        RST_N = 1'b1;
        #1;
        for (int i = 0; i < 12; i++) begin
            chk("contend", 32'(ReqReady), (i % 3 == 0) ? (32'(1) << ((i / 3) % NR)) : 32'h0);
            tick();
        end

        // fairness between requesters 0 and 2
        RST_N = 1'b0;
        ReqValid = 4'b0101;
        tick();
        RST_N = 1'b1;
        #1;
        for (int i = 0; i < 12; i++) begin
            chk("fair", 32'(ReqReady), (i % 3 != 0) ? 32'h0 : (((i / 3) % 2 == 1) ? 32'h4 : 32'h1));
            tick();
        end

        // reset during BUSY
        do_reset();
        ReqOperand1[3*32 +: 32] = rand_fp();
        ReqOperand2[3*32 +: 32] = rand_fp();
        ReqOperation[3*3 +: 3]  = OP_MUL;
        ReqValid = 4'b1000;
        #1;
        chk("busy_grant", 32'(ReqReady), 32'h8);
        tick();
        ReqValid = '0;
        #2;
        RST_N = 1'b0;
        #1;
        chk("arst_req_ready", 32'(ReqReady), 32'h0);
        chk("arst_resp_valid", 32'(RespValid), 32'h0);
        chk("arst_result", RespResult, 32'h0);
        chk("arst_error", 32'(RespError), 32'h0);
        chk("arst_fpu_op1", FpuOperand1, 32'h0);
        chk("arst_fpu_op2", FpuOperand2, 32'h0);
        chk("arst_fpu_opc", 32'(FpuOperation), 32'h0);
        tick();
        RST_N = 1'b1;
        repeat (3) begin
            tick();
            chk("arst_no_resp", 32'(RespValid), 32'h0);
        end
        ReqValid = '1;
        #1;
        chk("arst_ptr0", 32'(ReqReady), 32'h1);

        // randomized traffic against the transaction-level model
        do_reset();
        for (int n = 0; n < 16; n++) begin
            run_txn(4'($urandom_range(1, 15)), 1'b0, 0, 32'h0, 32'h0, OP_ADD,
                    $urandom_range(0, 3), res);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
